// File: rtl/stepper_package_pkg.sv
// Shared constants, axis state encoding and the signed target/position compare
// used by every stepper axis.
package stepper_package_pkg;

   localparam int AXES            = 6;
   localparam int WORD            = 32;
   localparam int HALF_PERIOD_DEF = 500;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } step_state_e;

   // Sign-extend both operands before subtracting so extreme values such as
   // 0x7FFFFFFF vs 0x80000000 cannot overflow into the wrong direction.
   function automatic logic target_above(input logic [WORD-1:0] target,
                                         input logic [WORD-1:0] position);
      logic signed [WORD:0] diff;
      diff = $signed({target[WORD-1], target}) - $signed({position[WORD-1], position});
      return !diff[WORD] && (diff != '0);
   endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper channel: direction setup, fixed-width step pulse and a
// signed 32-bit position that steps on each rising pulse edge.
//
// state | meaning
// IDLE  | at target or motion not allowed; waits for a move request
// SETUP | direction just loaded; holds off the first pulse for HALF_PERIOD
// HIGH  | step pulse asserted; position already updated on entry
// LOW   | pulse deasserted; at the end the next step is decided
module stepper_axis
   import stepper_package_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WORD-1:0] target,
   input  logic            power_on,
   input  logic            enable,
   output logic [WORD-1:0] position,
   output logic            pulse,
   output logic            direct
);

   localparam int            CW       = $clog2(HALF_PERIOD);
   localparam logic [CW-1:0] CNT_LOAD = CW'(HALF_PERIOD - 1);

   step_state_e     state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WORD-1:0] pos_q, pos_d;
   logic            pulse_q, pulse_d;
   logic            dir_q, dir_d;

   logic move_ok;
   logic want_up;
   logic phase_done;
   logic entering;

   assign move_ok    = power_on && enable && (target != pos_q);
   assign want_up    = target_above(target, pos_q);
   assign phase_done = (cnt_q == '0);
   assign entering   = (state_d != state_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pos_q   <= '0;
         pulse_q <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         pulse_q <= pulse_d;
         dir_q   <= dir_d;
      end
   end

   // Every phase runs to its terminal count; the target and the power/enable
   // inputs are only consulted in IDLE and at the end of LOW.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (move_ok) state_d = SETUP;
         end
         SETUP: begin
            if (phase_done) state_d = HIGH;
         end
         HIGH: begin
            if (phase_done) state_d = LOW;
         end
         LOW: begin
            if (phase_done) begin
               if (!move_ok)            state_d = IDLE;
               else if (want_up == dir_q) state_d = HIGH;
               else                     state_d = SETUP;
            end
         end
         default: state_d = IDLE;
      endcase

      cnt_d = cnt_q;
      if (entering)         cnt_d = (state_d == IDLE) ? '0 : CNT_LOAD;
      else if (!phase_done) cnt_d = cnt_q - CW'(1);
   end

   // Direction only reloads when entering SETUP, so it is always stable for a
   // full HALF_PERIOD before the next rising pulse edge.
   always_comb begin
      pulse_d = (state_d == HIGH);
      dir_d   = (entering && (state_d == SETUP)) ? want_up : dir_q;
      pos_d   = pos_q;
      if (entering && (state_d == HIGH)) begin
         pos_d = dir_q ? (pos_q + WORD'(1)) : (pos_q - WORD'(1));
      end
   end

   assign position = pos_q;
   assign pulse    = pulse_q;
   assign direct   = dir_q;

endmodule

// File: rtl/stepper_package.sv
// Six independent stepper axes sharing power/enable, with a registered
// common driver power enable.
module stepper_package
   import stepper_package_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [AXES*WORD-1:0] stepCnt,
   input  logic                 currentLoopPowerOn,
   input  logic                 currentLoopEnable,
   output logic [AXES*WORD-1:0] stepperPosition,
   output logic [AXES-1:0]      powerEN,
   output logic [AXES-1:0]      thrusterPluse,
   output logic [AXES-1:0]      thrusterDirect
);

   logic [AXES-1:0] power_en_q, power_en_d;

   assign power_en_d = {AXES{currentLoopPowerOn}};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) power_en_q <= '0;
      else     power_en_q <= power_en_d;
   end

   assign powerEN = power_en_q;

   for (genvar k = 0; k < AXES; k++) begin : g_axis
      stepper_axis #(
         .HALF_PERIOD (HALF_PERIOD)
      ) u_axis (
         .clk      (CLK),
         .rst      (RST),
         .target   (stepCnt[k*WORD +: WORD]),
         .power_on (currentLoopPowerOn),
         .enable   (currentLoopEnable),
         .position (stepperPosition[k*WORD +: WORD]),
         .pulse    (thrusterPluse[k]),
         .direct   (thrusterDirect[k])
      );
   end

endmodule

// File: tb/tb_stepper_package.sv
// Self-checking bench for stepper_package with HALF_PERIOD=4: expected pulses
// are queued as moves are commanded and compared as each rising edge appears.
module tb_stepper_package;
   import stepper_package_pkg::*;

   localparam int HP = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [191:0] stepCnt;
   logic         pw, en;
   logic [191:0] stepperPosition;
   logic [5:0]   powerEN, thrusterPluse, thrusterDirect;

   always #5 CLK = ~CLK;

   stepper_package #(.HALF_PERIOD(HP)) dut (
      .CLK                (CLK),
      .RST                (RST),
      .stepCnt            (stepCnt),
      .currentLoopPowerOn (pw),
      .currentLoopEnable  (en),
      .stepperPosition    (stepperPosition),
      .powerEN            (powerEN),
      .thrusterPluse      (thrusterPluse),
      .thrusterDirect     (thrusterDirect)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [2:0]  axis;
      logic        dir;
      logic [31:0] pos;
   } pexp_t;

   pexp_t exp_q[$];

   logic [5:0] prev_pulse, prev_dir, had_fall;
   int hi_run[6], fall_cyc[6], last_chg[6], rise_cnt[6], rev_gap[6];

   initial begin
      for (int i = 0; i < 6; i++) begin
         hi_run[i] = 0; fall_cyc[i] = 0; last_chg[i] = 0; rise_cnt[i] = 0; rev_gap[i] = 0;
      end
      prev_pulse = '0; prev_dir = '0; had_fall = '0;
   end

   function automatic logic [31:0] pos_of(input int a);
      return stepperPosition[32*a +: 32];
   endfunction

   always @(negedge CLK) begin
      pexp_t e;
      cyc++;
      if (RST) begin
         prev_pulse = '0; prev_dir = '0; had_fall = '0;
         for (int i = 0; i < 6; i++) begin
            hi_run[i] = 0; last_chg[i] = cyc;
         end
      end else begin
         for (int a = 0; a < 6; a++) begin
            if (thrusterDirect[a] != prev_dir[a]) begin
               last_chg[a] = cyc;
               chk("dir_while_high", {31'b0, thrusterPluse[a] | prev_pulse[a]}, 32'd0);
            end
            if (thrusterPluse[a] && !prev_pulse[a]) begin
               rise_cnt[a]++;
               chk("dir_setup", {31'b0, (cyc - last_chg[a]) >= HP}, 32'd1);
               if (had_fall[a] && last_chg[a] > fall_cyc[a])
                  rev_gap[a] = cyc - last_chg[a];
               else if (had_fall[a] && (cyc - fall_cyc[a]) <= 4*HP)
                  chk("low_width", 32'(cyc - fall_cyc[a]), 32'(HP));
               chk("pulse_expected", {31'b0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("pulse_axis", 32'(a), {29'b0, e.axis});
                  chk("pulse_dir", {31'b0, thrusterDirect[a]}, {31'b0, e.dir});
                  chk("pulse_pos", pos_of(a), e.pos);
               end
            end
            if (!thrusterPluse[a] && prev_pulse[a]) begin
               chk("high_width", 32'(hi_run[a]), 32'(HP));
               had_fall[a] = 1'b1;
               fall_cyc[a] = cyc;
            end
            hi_run[a] = thrusterPluse[a] ? hi_run[a] + 1 : 0;
         end
         prev_pulse = thrusterPluse;
         prev_dir   = thrusterDirect;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_target(input int a, input logic [31:0] v);
      stepCnt[32*a +: 32] = v;
   endtask

   task automatic push(input int a, input logic d, input logic [31:0] p);
      pexp_t e;
      e.axis = 3'(a); e.dir = d; e.pos = p;
      exp_q.push_back(e);
   endtask

   task automatic wait_pos(input int a, input logic [31:0] v, input int max);
      int n = 0;
      while (pos_of(a) !== v && n < max) begin tick(); n++; end
      chk("wait_pos", pos_of(a), v);
   endtask

   task automatic wait_rise(input int a, input int max);
      int n = 0;
      while (thrusterPluse[a] !== 1'b1 && n < max) begin tick(); n++; end
      chk("wait_pulse", {31'b0, thrusterPluse[a]}, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int total;
      RST = 1'b1; pw = 1'b0; en = 1'b0; stepCnt = '0;
      repeat (3) tick();
      chk("rst_power_en", {26'b0, powerEN}, 32'd0);
      chk("rst_pulse", {26'b0, thrusterPluse}, 32'd0);
      chk("rst_pos_zero", {31'b0, |stepperPosition}, 32'd0);

      // idle with all targets at zero
      RST = 1'b0; pw = 1'b1; en = 1'b1;
      tick();
      chk("power_en_on", {26'b0, powerEN}, 32'h3F);
      repeat (1000) tick();
      total = 0;
      for (int i = 0; i < 6; i++) total += rise_cnt[i];
      chk("idle_no_pulses", 32'(total), 32'd0);
      chk("idle_pos_zero", {31'b0, |stepperPosition}, 32'd0);

      // axis0 to +3
      push(0, 1'b1, 32'd1); push(0, 1'b1, 32'd2); push(0, 1'b1, 32'd3);
      set_target(0, 32'd3);
      tick();
      chk("ax0_dir_load", {31'b0, thrusterDirect[0]}, 32'd1);
      chk("ax0_no_pulse_yet", {31'b0, thrusterPluse[0]}, 32'd0);
      repeat (3) tick();
      chk("ax0_pre_rise", {31'b0, thrusterPluse[0]}, 32'd0);
      tick();
      chk("ax0_first_rise", {31'b0, thrusterPluse[0]}, 32'd1);
      repeat (40) tick();
      chk("ax0_pos", pos_of(0), 32'd3);
      chk("ax0_pulses", 32'(rise_cnt[0]), 32'd3);
      chk("others_untouched", {31'b0, |stepperPosition[191:32]}, 32'd0);
      chk("ax0_queue_empty", 32'(exp_q.size()), 32'd0);

      // axis2 to -2
      push(2, 1'b0, 32'hFFFF_FFFF); push(2, 1'b0, 32'hFFFF_FFFE);
      set_target(2, 32'hFFFF_FFFE);
      tick();
      chk("ax2_dir_neg", {31'b0, thrusterDirect[2]}, 32'd0);
      repeat (30) tick();
      chk("ax2_pos", pos_of(2), 32'hFFFF_FFFE);
      chk("ax2_pulses", 32'(rise_cnt[2]), 32'd2);

      // extreme target: a 32-bit subtract would pick the wrong direction here
      push(2, 1'b1, 32'hFFFF_FFFF); push(2, 1'b0, 32'hFFFF_FFFE);
      set_target(2, 32'h7FFF_FFFF);
      tick();
      chk("ax2_dir_extreme", {31'b0, thrusterDirect[2]}, 32'd1);
      wait_rise(2, 20);
      set_target(2, 32'hFFFF_FFFE);
      repeat (40) tick();
      chk("ax2_pos_back", pos_of(2), 32'hFFFF_FFFE);
      chk("ax2_rev_gap", 32'(rev_gap[2]), 32'(HP));
      chk("ax2_queue_empty", 32'(exp_q.size()), 32'd0);

      // axis1 reverses mid-move
      for (int p = 1; p <= 4; p++) push(1, 1'b1, 32'(p));
      for (int p = 3; p >= -1; p--) push(1, 1'b0, 32'(p));
      set_target(1, 32'd10);
      wait_pos(1, 32'd4, 200);
      set_target(1, 32'hFFFF_FFFF);
      repeat (80) tick();
      chk("ax1_pos", pos_of(1), 32'hFFFF_FFFF);
      chk("ax1_rev_setup", 32'(rev_gap[1]), 32'(HP));
      chk("ax1_pulses", 32'(rise_cnt[1]), 32'd9);
      chk("ax1_queue_empty", 32'(exp_q.size()), 32'd0);

      // axis3: enable dropped during a pulse, then restored
      push(3, 1'b1, 32'd1); push(3, 1'b1, 32'd2);
      set_target(3, 32'd5);
      wait_pos(3, 32'd2, 100);
      en = 1'b0;
      tick();
      chk("ax3_pulse_held", {31'b0, thrusterPluse[3]}, 32'd1);
      repeat (40) tick();
      chk("ax3_frozen", pos_of(3), 32'd2);
      chk("ax3_pulse_low", {31'b0, thrusterPluse[3]}, 32'd0);
      chk("ax3_no_extra", 32'(exp_q.size()), 32'd0);
      push(3, 1'b1, 32'd3); push(3, 1'b1, 32'd4); push(3, 1'b1, 32'd5);
      en = 1'b1;
      repeat (60) tick();
      chk("ax3_resumed", pos_of(3), 32'd5);
      chk("ax3_pulses", 32'(rise_cnt[3]), 32'd5);

      // axis4: reset asserted mid-HIGH
      push(4, 1'b1, 32'd1); push(4, 1'b1, 32'd2); push(4, 1'b1, 32'd3);
      set_target(4, 32'd3);
      wait_rise(4, 20);
      tick();
      RST = 1'b1;
      #1;
      chk("rst_async_pulse", {26'b0, thrusterPluse}, 32'd0);
      chk("rst_async_pos", {31'b0, |stepperPosition}, 32'd0);
      chk("rst_async_dir", {26'b0, thrusterDirect}, 32'd0);
      chk("rst_async_power_en", {26'b0, powerEN}, 32'd0);
      exp_q.delete();
      tick();
      RST = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/stepper_package.md
STEPPER_PACKAGE -- requirements
Module: stepper_package

Interface
REQ-001 HALF_PERIOD, default 500, number of clock cycles in each pulse-high, pulse-low and direction-setup phase; legal range is 2 or more.
REQ-002 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 stepCnt  in  192  six signed 32-bit absolute target positions; axis k uses bits [32k+31:32k].
REQ-005 currentLoopPowerOn  in  1  driver power request, common to all six axes.
REQ-006 currentLoopEnable  in  1  motion enable, common to all six axes.
REQ-007 stepperPosition  out  192  six signed 32-bit current positions, packed the same way as stepCnt.
REQ-008 powerEN  out  6  per-axis driver power enable.
REQ-009 thrusterPluse  out  6  per-axis step pulse, active high.
REQ-010 thrusterDirect  out  6  per-axis direction; 1 = positive (increment), 0 = negative.

Function
REQ-011 All outputs SHALL be registered, and the six axes SHALL operate independently and identically.
REQ-012 powerEN SHALL be {6{currentLoopPowerOn}}, registered with 1 cycle of latency.
REQ-013 Each axis SHALL run a state machine with states IDLE, SETUP, HIGH and LOW.
REQ-014 In IDLE, the axis SHALL go to SETUP on the next edge when currentLoopPowerOn=1, currentLoopEnable=1 and target != position; thrusterDirect is loaded on that same edge with (target > position).
REQ-015 The target-versus-position comparison SHALL be a signed 33-bit subtraction, so that wrapped or extreme values never select the wrong direction.
REQ-016 SETUP SHALL last HALF_PERIOD cycles, then the axis enters HIGH.
REQ-017 On entry to HIGH, thrusterPluse SHALL go to 1 and position SHALL change by ±1 per thrusterDirect on that same edge.
REQ-018 HIGH SHALL last HALF_PERIOD cycles with the pulse at 1, then the axis enters LOW with the pulse at 0.
REQ-019 After HALF_PERIOD cycles in LOW, the axis re-evaluates the target and power/enable:
  - still allowed and the direction is unchanged: go to HIGH (step period = 2*HALF_PERIOD);
  - still allowed and the direction must reverse: update thrusterDirect and go to SETUP;
  - otherwise: go to IDLE.
REQ-020 The target SHALL be sampled only at IDLE and LOW decision points; a target change during SETUP or HIGH takes effect at the next decision point.
REQ-021 Dropping currentLoopEnable or currentLoopPowerOn mid-step SHALL NOT truncate a pulse; the current HIGH/LOW completes and the axis then returns to IDLE.
REQ-022 thrusterDirect SHALL never change while thrusterPluse=1 or within HALF_PERIOD cycles before a rising pulse edge.
REQ-023 Position SHALL wrap in two's complement at the 32-bit limits, with no saturation.
REQ-024 When target == position, no pulses SHALL be generated, and the position SHALL hold indefinitely.

Reset
REQ-025 When RST is asserted, SHALL set, asynchronously and at any time including mid-pulse:
  - all positions to 0;
  - thrusterPluse, thrusterDirect and powerEN to 0;
  - every state machine to IDLE;
  - all phase counters to 0.
REQ-026 After RST deasserts, the first motion SHALL start no earlier than the first rising edge of CLK.

Structure
REQ-027 A shared package SHALL hold:
  - AXES=6 and WORD=32;
  - the state enumeration IDLE/SETUP/HIGH/LOW;
  - the HALF_PERIOD default.
REQ-028 One sub-module, stepper_axis (one target, one position, one pulse/direction pair, one phase counter), SHALL be instantiated AXES times by stepper_package, with the 192-bit buses sliced per axis.

Verification (HALF_PERIOD=4)
REQ-029 Reset, then power=1, enable=1, all targets 0: powerEN=6'h3F after 1 cycle; no pulses in 1000 cycles; all positions 0.
REQ-030 Axis0 target=3 from idle:
  - thrusterDirect[0]=1 next cycle;
  - first rising pulse edge 4 cycles later;
  - exactly 3 pulses, each high 4 cycles and low 4 cycles;
  - position[0]=3; axes 1-5 untouched.
REQ-031 Axis2 target=-2 from position 0: thrusterDirect[2]=0, 2 pulses, position reads 0xFFFFFFFE.
REQ-032 Axis1 moving toward 10, target changed to -1 after position reaches 4:
  - pulse completes, then SETUP of 4 cycles with thrusterDirect[1]=0;
  - position ends at -1;
  - thrusterDirect never toggles while the pulse is high.
REQ-033 enable dropped while a pulse is high: the pulse still lasts 4 cycles, no further pulses follow, and the position freezes; re-enabling resumes motion toward the target.
REQ-034 RST asserted mid-HIGH: pulse, position, direction and powerEN go to 0 immediately, without waiting for a clock edge.
